// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin denominations, hopper
// selection encoding, FSM state encoding and small arithmetic helpers.
package change_dispenser_pkg;

  localparam logic [7:0] COIN_50 = 8'd50;
  localparam logic [7:0] COIN_10 = 8'd10;
  localparam logic [7:0] COIN_5  = 8'd5;
  localparam logic [7:0] COIN_1  = 8'd1;

  // Hopper index; the same encoding is used on refill_sel.
  typedef enum logic [1:0] {
    SEL_50 = 2'd0,
    SEL_10 = 2'd1,
    SEL_5  = 2'd2,
    SEL_1  = 2'd3
  } hopper_sel_e;

  // Payout FSM states, shared with the vending FSM.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Face value of the coin held in a hopper.
  function automatic logic [7:0] coin_of(input hopper_sel_e sel);
    case (sel)
      SEL_50:  return COIN_50;
      SEL_10:  return COIN_10;
      SEL_5:   return COIN_5;
      default: return COIN_1;
    endcase
  endfunction

  // New hopper level after adding `add` coins and removing `sub` coins,
  // clamped to the 8-bit range. The net value is formed before clamping so
  // a refill and an eject in the same cycle combine correctly.
  function automatic logic [7:0] sat_level(input logic [7:0] level,
                                           input logic [7:0] add,
                                           input logic       sub);
    logic [8:0] sum;
    sum = {1'b0, level} + {1'b0, add};
    if (sub && (sum != 9'd0)) sum = sum - 9'd1;
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request and coin-eject handshakes of the change dispenser. The master side
// is the vending FSM together with the hopper mechanism that returns coin_ack.
interface change_dispenser_if;
  logic [7:0] change_amount;
  logic       change_valid;
  logic       change_ready;
  logic [7:0] coin_value;
  logic       coin_valid;
  logic       coin_ack;

  modport master (
    output change_amount, change_valid, coin_ack,
    input  change_ready, coin_value, coin_valid
  );

  modport slave (
    input  change_amount, change_valid, coin_ack,
    output change_ready, coin_value, coin_valid
  );
endinterface

// File: rtl/change_dispenser_hopper.sv
// One coin hopper level counter: loads its initial count on reset, accepts
// refills and single-coin decrements, and saturates at 255.
module coin_hopper_counter
  import change_dispenser_pkg::*;
#(
  parameter logic [7:0] INIT = 8'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refill,
  input  logic [7:0] qty,
  input  logic       dec,
  output logic [7:0] level,
  output logic       empty
);

  // Hopper level: reset loads the initial stock, otherwise refill/eject net.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= INIT;
    end else if (refill || dec) begin
      level <= sat_level(level, refill ? qty : 8'd0, dec);
    end
  end

  assign empty = (level == 8'd0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a requested amount one coin at a time using a
// greedy 50/10/5/1 order, skipping empty hoppers, and reports any shortfall.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter logic [7:0] INIT_INV_50 = 8'd10,
  parameter logic [7:0] INIT_INV_10 = 8'd20,
  parameter logic [7:0] INIT_INV_5  = 8'd20,
  parameter logic [7:0] INIT_INV_1  = 8'd50
) (
  input  logic                     clk,
  input  logic                     reset,
  change_dispenser_if.slave        bus,
  input  logic                     refill_en,
  input  logic [1:0]               refill_sel,
  input  logic [7:0]               refill_qty,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               short_amount,
  output logic [7:0]               inv_50,
  output logic [7:0]               inv_10,
  output logic [7:0]               inv_5,
  output logic [7:0]               inv_1
);

  state_e          state;
  state_e          state_nxt;
  logic [7:0]      remaining;
  logic [7:0]      rem_after;
  logic [7:0]      coin_value;
  logic            coin_valid;
  hopper_sel_e     coin_sel;
  logic            pick_found;
  hopper_sel_e     pick_sel;
  logic [7:0]      pick_value;
  logic [3:0]      empty;
  logic [3:0]      refill_hit;
  logic [3:0]      dec_hit;
  logic [3:0][7:0] level;

  coin_hopper_counter #(.INIT(INIT_INV_50)) u_hopper_50 (
    .clk(clk), .reset(reset), .refill(refill_hit[SEL_50]), .qty(refill_qty),
    .dec(dec_hit[SEL_50]), .level(level[SEL_50]), .empty(empty[SEL_50])
  );
  coin_hopper_counter #(.INIT(INIT_INV_10)) u_hopper_10 (
    .clk(clk), .reset(reset), .refill(refill_hit[SEL_10]), .qty(refill_qty),
    .dec(dec_hit[SEL_10]), .level(level[SEL_10]), .empty(empty[SEL_10])
  );
  coin_hopper_counter #(.INIT(INIT_INV_5)) u_hopper_5 (
    .clk(clk), .reset(reset), .refill(refill_hit[SEL_5]), .qty(refill_qty),
    .dec(dec_hit[SEL_5]), .level(level[SEL_5]), .empty(empty[SEL_5])
  );
  coin_hopper_counter #(.INIT(INIT_INV_1)) u_hopper_1 (
    .clk(clk), .reset(reset), .refill(refill_hit[SEL_1]), .qty(refill_qty),
    .dec(dec_hit[SEL_1]), .level(level[SEL_1]), .empty(empty[SEL_1])
  );

  // Route refills by refill_sel; decrement the ejected hopper on coin_ack.
  always_comb begin
    refill_hit = '0;
    dec_hit    = '0;
    for (int i = 0; i < 4; i++) begin
      refill_hit[i] = refill_en && (refill_sel == i[1:0]);
      dec_hit[i]    = (state == ST_ISSUE) && bus.coin_ack &&
                      (coin_sel == hopper_sel_e'(i[1:0]));
    end
  end

  // Greedy pick: scan from the 1 hopper up to the 50 hopper so the largest
  // usable denomination that still fits the remainder wins.
  always_comb begin
    pick_found = 1'b0;
    pick_sel   = SEL_1;
    for (int i = 3; i >= 0; i--) begin
      if (!empty[i] && (coin_of(hopper_sel_e'(i[1:0])) <= remaining)) begin
        pick_found = 1'b1;
        pick_sel   = hopper_sel_e'(i[1:0]);
      end
    end
  end

  assign pick_value = coin_of(pick_sel);
  // Cannot underflow: coin_value was chosen with coin_value <= remaining.
  assign rem_after  = remaining - coin_value;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state decode.
  // NOTE: the default assignment first means every path assigns state_nxt,
  // so no latch is inferred for the states that simply hold.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.change_valid)
          state_nxt = (bus.change_amount == 8'd0) ? ST_DONE : ST_SELECT;
      end
      ST_SELECT: state_nxt = pick_found ? ST_ISSUE : ST_DONE;
      ST_ISSUE: begin
        if (bus.coin_ack)
          state_nxt = (rem_after == 8'd0) ? ST_DONE : ST_SELECT;
      end
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Payout datapath and registered outputs; reset abandons any payout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining    <= 8'd0;
      coin_value   <= 8'd0;
      coin_valid   <= 1'b0;
      coin_sel     <= SEL_50;
      done         <= 1'b0;
      short_amount <= 8'd0;
    end else begin
      coin_valid <= (state_nxt == ST_ISSUE);
      done       <= (state_nxt == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (bus.change_valid) begin
            remaining    <= bus.change_amount;
            short_amount <= 8'd0;
          end
        end
        ST_SELECT: begin
          if (pick_found) begin
            coin_value <= pick_value;
            coin_sel   <= pick_sel;
          end else begin
            short_amount <= remaining;
          end
        end
        ST_ISSUE: begin
          if (bus.coin_ack) begin
            remaining  <= rem_after;
            coin_value <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.change_ready = (state == ST_IDLE);
  assign busy             = (state != ST_IDLE);
  assign bus.coin_value   = coin_value;
  assign bus.coin_valid   = coin_valid;

  assign inv_50 = level[SEL_50];
  assign inv_10 = level[SEL_10];
  assign inv_5  = level[SEL_5];
  assign inv_1  = level[SEL_1];

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser. Unit A uses the default hopper
// stock; unit B starts with an empty 50 hopper, one 5 coin and two 1 coins.
module tb_change_dispenser;

  typedef struct packed {
    logic       is_done;
    logic [7:0] value;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       refill_en_a = 1'b0, refill_en_b = 1'b0;
  logic [1:0] refill_sel_a = 2'd0, refill_sel_b = 2'd0;
  logic [7:0] refill_qty_a = 8'd0, refill_qty_b = 8'd0;
  logic       busy_a, done_a, busy_b, done_b;
  logic [7:0] short_a, inv50_a, inv10_a, inv5_a, inv1_a;
  logic [7:0] short_b, inv50_b, inv10_b, inv5_b, inv1_b;

  ev_t q_a[$];
  ev_t q_b[$];
  int  checks = 0;
  int  failures = 0;
  bit  ack_block_a = 1'b0;
  bit  prev_cv_a = 1'b0;
  bit  prev_cv_b = 1'b0;

  change_dispenser_if bus_a ();
  change_dispenser_if bus_b ();

  change_dispenser dut_a (
    .clk(clk), .reset(reset), .bus(bus_a),
    .refill_en(refill_en_a), .refill_sel(refill_sel_a), .refill_qty(refill_qty_a),
    .busy(busy_a), .done(done_a), .short_amount(short_a),
    .inv_50(inv50_a), .inv_10(inv10_a), .inv_5(inv5_a), .inv_1(inv1_a)
  );

  change_dispenser #(
    .INIT_INV_50(8'd0), .INIT_INV_10(8'd20), .INIT_INV_5(8'd1), .INIT_INV_1(8'd2)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b),
    .refill_en(refill_en_b), .refill_sel(refill_sel_b), .refill_qty(refill_qty_b),
    .busy(busy_b), .done(done_b), .short_amount(short_b),
    .inv_50(inv50_b), .inv_10(inv10_b), .inv_5(inv5_b), .inv_1(inv1_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Pop the next expected event of a unit and compare with what it produced.
  task automatic score(input int dut, input ev_t got);
    ev_t exp;
    bit  have;
    checks++;
    have = (dut == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
    if (!have) begin
      failures++;
      $display("FAIL unit%0d unexpected_event: got %s %0d expected nothing",
               dut, got.is_done ? "done/short" : "coin", got.value);
    end else begin
      exp = (dut == 0) ? q_a.pop_front() : q_b.pop_front();
      if (got !== exp) begin
        failures++;
        $display("FAIL unit%0d event: got %s %0d expected %s %0d", dut,
                 got.is_done ? "done/short" : "coin", got.value,
                 exp.is_done ? "done/short" : "coin", exp.value);
      end
    end
  endtask

  // Hopper model: acknowledge an eject in the cycle after it is requested.
  always @(negedge clk) begin
    bus_a.coin_ack = bus_a.coin_valid && !ack_block_a;
    bus_b.coin_ack = bus_b.coin_valid;
  end

  // Monitor: a new coin on each rising coin_valid, a result on each done.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_a.coin_valid && !prev_cv_a) score(0, {1'b0, bus_a.coin_value});
      if (done_a)                         score(0, {1'b1, short_a});
      if (bus_b.coin_valid && !prev_cv_b) score(1, {1'b0, bus_b.coin_value});
      if (done_b)                         score(1, {1'b1, short_b});
    end
    prev_cv_a = bus_a.coin_valid;
    prev_cv_b = bus_b.coin_valid;
  end

  task automatic expect_ev(input int dut, input logic is_done, input logic [7:0] value);
    ev_t e;
    e.is_done = is_done;
    e.value   = value;
    if (dut == 0) q_a.push_back(e);
    else          q_b.push_back(e);
  endtask

  // Present a request for one cycle; returns one sample after the accept edge.
  task automatic send(input int dut, input logic [7:0] amt);
    @(negedge clk);
    if (dut == 0) begin
      check("ready_before_send_a", bus_a.change_ready, 1);
      bus_a.change_amount = amt;
      bus_a.change_valid  = 1'b1;
    end else begin
      check("ready_before_send_b", bus_b.change_ready, 1);
      bus_b.change_amount = amt;
      bus_b.change_valid  = 1'b1;
    end
    @(negedge clk);
    bus_a.change_valid = 1'b0;
    bus_b.change_valid = 1'b0;
  endtask

  task automatic wait_idle(input int dut);
    int n = 0;
    while (((dut == 0) ? !bus_a.change_ready : !bus_b.change_ready) && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", (n < 300), 1);
  endtask

  task automatic wait_coin_a();
    int n = 0;
    while (!bus_a.coin_valid && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    check("coin_valid_within_budget", bus_a.coin_valid, 1);
  endtask

  task automatic refill_a(input logic [1:0] sel, input logic [7:0] qty);
    @(negedge clk);
    refill_en_a  = 1'b1;
    refill_sel_a = sel;
    refill_qty_a = qty;
    @(negedge clk);
    refill_en_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.change_valid = 1'b0; bus_a.change_amount = 8'd0;
    bus_b.change_valid = 1'b0; bus_b.change_amount = 8'd0;
    repeat (3) @(negedge clk);

    // Reset state of both units.
    check("rst_ready_a", bus_a.change_ready, 1);
    check("rst_busy_a", busy_a, 0);
    check("rst_coin_valid_a", bus_a.coin_valid, 0);
    check("rst_coin_value_a", bus_a.coin_value, 0);
    check("rst_done_a", done_a, 0);
    check("rst_short_a", short_a, 0);
    check("rst_inv50_a", inv50_a, 10);
    check("rst_inv10_a", inv10_a, 20);
    check("rst_inv5_a", inv5_a, 20);
    check("rst_inv1_a", inv1_a, 50);
    check("rst_inv50_b", inv50_b, 0);
    check("rst_inv5_b", inv5_b, 1);
    check("rst_inv1_b", inv1_b, 2);
    reset = 1'b0;

    // 37 from full hoppers: 10,10,10,5,1,1.
    expect_ev(0, 0, 10); expect_ev(0, 0, 10); expect_ev(0, 0, 10);
    expect_ev(0, 0, 5);  expect_ev(0, 0, 1);  expect_ev(0, 0, 1);
    expect_ev(0, 1, 0);
    send(0, 8'd37);
    check("t1_busy_after_accept", busy_a, 1);
    check("t1_no_coin_in_select", bus_a.coin_valid, 0);
    @(negedge clk);
    check("t1_coin_valid_2nd_cycle", bus_a.coin_valid, 1);
    check("t1_first_coin_value", bus_a.coin_value, 10);
    wait_idle(0);
    check("t1_inv50", inv50_a, 10);
    check("t1_inv10", inv10_a, 17);
    check("t1_inv5", inv5_a, 19);
    check("t1_inv1", inv1_a, 48);
    check("t1_short", short_a, 0);

    // 65 with no 50 coins: six 10s then a 5.
    for (int i = 0; i < 6; i++) expect_ev(1, 0, 10);
    expect_ev(1, 0, 5);
    expect_ev(1, 1, 0);
    send(1, 8'd65);
    wait_idle(1);
    check("t2_inv50_untouched", inv50_b, 0);
    check("t2_inv10", inv10_b, 14);
    check("t2_inv5_empty", inv5_b, 0);

    // 8 with the 5 hopper empty and two 1 coins: 1,1 then short 6.
    expect_ev(1, 0, 1); expect_ev(1, 0, 1); expect_ev(1, 1, 6);
    send(1, 8'd8);
    wait_idle(1);
    check("t3_short_held", short_b, 6);
    check("t3_inv1_empty", inv1_b, 0);
    check("t3_inv10", inv10_b, 14);

    // Zero amount: no coin, done in the cycle right after the accept edge.
    expect_ev(0, 1, 0);
    send(0, 8'd0);
    check("t4_done", done_a, 1);
    check("t4_no_coin", bus_a.coin_valid, 0);
    wait_idle(0);
    check("t4_short", short_a, 0);

    // Ack held off: coin_value stays stable and a new request is ignored.
    ack_block_a = 1'b1;
    expect_ev(0, 0, 10); expect_ev(0, 0, 1); expect_ev(0, 0, 1); expect_ev(0, 1, 0);
    send(0, 8'd12);
    wait_coin_a();
    for (int i = 0; i < 5; i++) begin
      check("t5_coin_valid_held", bus_a.coin_valid, 1);
      check("t5_coin_value_stable", bus_a.coin_value, 10);
      check("t5_not_ready", bus_a.change_ready, 0);
      if (i == 0) begin
        bus_a.change_amount = 8'd20;
        bus_a.change_valid  = 1'b1;
      end
      @(negedge clk);
    end
    bus_a.change_valid = 1'b0;
    ack_block_a = 1'b0;
    wait_idle(0);
    check("t5_inv10", inv10_a, 16);
    check("t5_inv1", inv1_a, 46);

    // Refill saturation, then refill and eject of the 1 hopper together.
    refill_a(2'd3, 8'd208);
    check("t6_inv1_refilled", inv1_a, 254);
    refill_a(2'd0, 8'd255);
    check("t6_inv50_saturated", inv50_a, 255);
    expect_ev(0, 0, 1); expect_ev(0, 1, 0);
    send(0, 8'd1);
    wait_coin_a();
    refill_en_a  = 1'b1;
    refill_sel_a = 2'd3;
    refill_qty_a = 8'd3;
    @(negedge clk);
    refill_en_a = 1'b0;
    check("t6_inv1_net_saturated", inv1_a, 255);
    wait_idle(0);

    // Reset while a coin is being ejected: cleared at once, no done pulse.
    expect_ev(0, 0, 10);
    send(0, 8'd37);
    wait_coin_a();
    #1 reset = 1'b1;
    #1;
    check("rst_mid_coin_valid", bus_a.coin_valid, 0);
    check("rst_mid_coin_value", bus_a.coin_value, 0);
    check("rst_mid_ready", bus_a.change_ready, 1);
    check("rst_mid_busy", busy_a, 0);
    check("rst_mid_done", done_a, 0);
    check("rst_mid_inv1_reload", inv1_a, 50);
    check("rst_mid_inv50_reload", inv50_a, 10);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_mid_no_done", done_a, 0);
    end

    check("queue_a_drained", q_a.size(), 0);
    check("queue_b_drained", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
